// File: rtl/spinnaker_fpgas_spi_reg_bridge.sv
// SPI mode-0 slave that turns one CMD/ADDR/DATA frame per chip-select into a
// register-bank write strobe, or shifts the bank's read data back out on MISO.
module spinnaker_fpgas_spi_reg_bridge #(
  parameter int REGA_BITS = 14,
  parameter int REGD_BITS = 32
) (
  input  logic                 CLK_IN,
  input  logic                 RESET_IN,
  input  logic                 SPI_NSS_IN,
  input  logic                 SPI_SCLK_IN,
  input  logic                 SPI_MOSI_IN,
  output logic                 SPI_MISO_OUT,
  output logic                 REG_WRITE_OUT,
  output logic [REGA_BITS-1:0] REG_ADDR_OUT,
  output logic [REGD_BITS-1:0] REG_WRITE_DATA_OUT,
  input  logic [REGD_BITS-1:0] REG_READ_DATA_IN
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [5:0] CNT_CMD_END  = 6'd7;
  localparam logic [5:0] CNT_ADDR_END = 6'd15;
  localparam logic [5:0] CNT_DATA_END = 6'(REGD_BITS - 1);

  logic [1:0]           r_nss_sync;
  logic [2:0]           r_sclk_sync;
  logic [1:0]           r_mosi_sync;
  logic [2:0]           r_state;
  logic [5:0]           r_cnt;
  logic                 r_cmd_wr;
  logic                 r_rd_load;
  logic [REGD_BITS-2:0] r_rx;
  logic [REGD_BITS-1:0] r_tx;

  logic                 w_nss_hi;
  logic                 w_mosi;
  logic                 w_rise;
  logic                 w_fall;
  logic [REGD_BITS-1:0] w_rx_next;

  // Stage [1] is the synchronised value; SCLK keeps a third history flop for edge detection.
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      r_nss_sync  <= 2'b11;
      r_sclk_sync <= 3'b000;
      r_mosi_sync <= 2'b00;
    end else begin
      r_nss_sync  <= {r_nss_sync[0], SPI_NSS_IN};
      r_sclk_sync <= {r_sclk_sync[1:0], SPI_SCLK_IN};
      r_mosi_sync <= {r_mosi_sync[0], SPI_MOSI_IN};
    end
  end

  assign w_nss_hi  = r_nss_sync[1];
  assign w_mosi    = r_mosi_sync[1];
  assign w_rise    = r_sclk_sync[1] & ~r_sclk_sync[2] & ~w_nss_hi;
  assign w_fall    = ~r_sclk_sync[1] & r_sclk_sync[2] & ~w_nss_hi;
  assign w_rx_next = {r_rx, w_mosi};

  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      r_state            <= ST_IDLE;
      r_cnt              <= 6'd0;
      r_cmd_wr           <= 1'b0;
      r_rd_load          <= 1'b0;
      r_rx               <= '0;
      r_tx               <= '0;
      SPI_MISO_OUT       <= 1'b0;
      REG_WRITE_OUT      <= 1'b0;
      REG_ADDR_OUT       <= '0;
      REG_WRITE_DATA_OUT <= '0;
    end else begin
      REG_WRITE_OUT <= 1'b0;
      r_rd_load     <= 1'b0;
      // Bank read data is valid one cycle after the address register settles.
      if (r_rd_load) r_tx <= REG_READ_DATA_IN;

      if (w_nss_hi) begin
        r_state      <= ST_IDLE;
        r_cnt        <= 6'd0;
        SPI_MISO_OUT <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_CMD;
            r_cnt   <= 6'd0;
          end
          ST_CMD: if (w_rise) begin
            r_rx <= w_rx_next[REGD_BITS-2:0];
            if (r_cnt == 6'd0) r_cmd_wr <= w_mosi;
            if (r_cnt == CNT_CMD_END) begin
              r_state <= ST_ADDR;
              r_cnt   <= 6'd0;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
          ST_ADDR: if (w_rise) begin
            r_rx <= w_rx_next[REGD_BITS-2:0];
            if (r_cnt == CNT_ADDR_END) begin
              r_state      <= ST_DATA;
              r_cnt        <= 6'd0;
              REG_ADDR_OUT <= w_rx_next[REGA_BITS-1:0];
              r_rd_load    <= ~r_cmd_wr;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
          ST_DATA: begin
            if (w_rise) begin
              r_rx <= w_rx_next[REGD_BITS-2:0];
              if (r_cnt == CNT_DATA_END) begin
                r_state      <= ST_DONE;
                r_cnt        <= 6'd0;
                SPI_MISO_OUT <= 1'b0;
                if (r_cmd_wr) begin
                  REG_WRITE_DATA_OUT <= w_rx_next;
                  REG_WRITE_OUT      <= 1'b1;
                end
              end else begin
                r_cnt <= r_cnt + 6'd1;
              end
            end else if (w_fall && !r_cmd_wr) begin
              SPI_MISO_OUT <= r_tx[REGD_BITS-1];
              r_tx         <= {r_tx[REGD_BITS-2:0], 1'b0};
            end
          end
          ST_DONE: SPI_MISO_OUT <= 1'b0;
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= 6'd0;
          end
        endcase
      end
    end
  end

endmodule
